// File: rtl/fn_suma_resta_seg_pkg.sv
// rtl/fn_suma_resta_seg_pkg.sv - ALU opcode constants and flag-vector layout shared with the ALU decoder
package fn_suma_resta_seg_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLT  = 4'd2;
   localparam logic [3:0] OP_SLTU = 4'd3;

   localparam int FLG_C   = 0;
   localparam int FLG_V   = 1;
   localparam int FLG_Z   = 2;
   localparam int FLG_LT  = 3;
   localparam int FLG_LTU = 4;
   localparam int NFLG    = 5;

   typedef logic [NFLG-1:0] flags_t;

endpackage

// File: rtl/fn_suma_resta_tramo.sv
// rtl/fn_suma_resta_tramo.sv - CHUNK-bit adder segment with carry-out and carry-into-MSB
module fn_suma_resta_tramo #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
      // carry into the top bit recovered from the sum bit, valid for CHUNK==1 too
      cmsb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
   end

endmodule

// File: rtl/fn_suma_resta_seg.sv
// rtl/fn_suma_resta_seg.sv - pipelined add/subtract, one CHUNK-bit segment per stage; SUMA_RESTA_SAT_EN enables saturation
module fn_suma_resta_seg
   import fn_suma_resta_seg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             resta,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             lt,
   output logic             ltu
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int L      = STAGES - 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("fn_suma_resta_seg: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   // stage registers: index k holds the beat after segment k has been resolved
   logic             v_q [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] y_q [STAGES];
   logic             c_q [STAGES];
   logic             r_q [STAGES];
   flags_t           flg_q;

   logic             v_s [STAGES];
   logic [WIDTH-1:0] a_s [STAGES];
   logic [WIDTH-1:0] b_s [STAGES];
   logic [WIDTH-1:0] y_s [STAGES];
   logic             c_s [STAGES];
   logic             r_s [STAGES];
   logic [WIDTH-1:0] y_nx [STAGES];

   logic [CHUNK-1:0] s_w  [STAGES];
   logic             co_w [STAGES];
   logic             cm_w [STAGES];

   logic             stall;
   logic             v_last;
   logic [WIDTH-1:0] y_fin;
   flags_t           flg_nx;

   assign stall     = v_q[L] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v_q[L];
   assign Y         = y_q[L];
   assign carry     = flg_q[FLG_C];
   assign overflow  = flg_q[FLG_V];
   assign zero      = flg_q[FLG_Z];
   assign lt        = flg_q[FLG_LT];
   assign ltu       = flg_q[FLG_LTU];

   always_comb begin
      v_s[0] = in_valid;
      a_s[0] = a;
      b_s[0] = b ^ {WIDTH{resta}};
      y_s[0] = '0;
      c_s[0] = resta;
      r_s[0] = resta;
      for (int k = 1; k < STAGES; k++) begin
         v_s[k] = v_q[k-1];
         a_s[k] = a_q[k-1];
         b_s[k] = b_q[k-1];
         y_s[k] = y_q[k-1];
         c_s[k] = c_q[k-1];
         r_s[k] = r_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         y_nx[k] = y_s[k];
         y_nx[k][k*CHUNK +: CHUNK] = s_w[k];
      end
   end

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_tramo
         fn_suma_resta_tramo #(.CHUNK(CHUNK)) u_tramo (
            .a    (a_s[k][k*CHUNK +: CHUNK]),
            .b    (b_s[k][k*CHUNK +: CHUNK]),
            .cin  (c_s[k]),
            .s    (s_w[k]),
            .cout (co_w[k]),
            .cmsb (cm_w[k])
         );
      end
   endgenerate

   // flags come from the unsaturated sum; only Y and zero see saturation
   always_comb begin
      v_last = co_w[L] ^ cm_w[L];
      y_fin  = y_nx[L];
`ifdef SUMA_RESTA_SAT_EN
      if (v_last) begin
         y_fin = a_s[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flg_nx          = '0;
      flg_nx[FLG_C]   = co_w[L];
      flg_nx[FLG_V]   = v_last;
      flg_nx[FLG_Z]   = (y_fin == '0);
      flg_nx[FLG_LT]  = r_s[L] & (y_nx[L][WIDTH-1] ^ v_last);
      flg_nx[FLG_LTU] = r_s[L] & ~co_w[L];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            y_q[k] <= '0;
            c_q[k] <= 1'b0;
            r_q[k] <= 1'b0;
         end
         flg_q <= '0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_s[k];
            a_q[k] <= a_s[k];
            b_q[k] <= b_s[k];
            y_q[k] <= y_nx[k];
            c_q[k] <= co_w[k];
            r_q[k] <= r_s[k];
         end
         y_q[L] <= y_fin;
         flg_q  <= flg_nx;
      end
   end

endmodule

// File: tb/tb_fn_suma_resta_seg.sv
// tb/tb_fn_suma_resta_seg.sv - directed and model-checked bench for fn_suma_resta_seg (WIDTH=32, CHUNK=8)
module tb_fn_suma_resta_seg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        resta;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Y;
   logic        carry;
   logic        overflow;
   logic        zero;
   logic        lt;
   logic        ltu;

   int checks   = 0;
   int failures = 0;

   fn_suma_resta_seg #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .resta     (resta),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .lt        (lt),
      .ltu       (ltu)
   );

   always #5 clk = ~clk;

   // flag order used throughout: {carry, overflow, zero, lt, ltu}
   task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic r);
      a = aa; b = bb; resta = r; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; resta = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      checks++;
      if (Y !== 32'h0 || {carry, overflow, zero, lt, ltu} !== 5'b0) begin
         failures++; $display("FAIL reset_data Y=%h flags=%b required 0/00000", Y, {carry, overflow, zero, lt, ltu});
      end
      @(negedge clk);
   endtask

   task automatic test_add_basic;
      int n;
      drive(32'd5, 32'd3, 1'b0);
      wait_out(n);
      checks++;
      if (n !== 3 || out_valid !== 1'b1) begin
         failures++; $display("FAIL add_latency cycles_after_accept=%0d required 3 (+1)", n);
      end
      checks++;
      if (Y !== 32'd8 || {carry, overflow, zero, lt, ltu} !== 5'b00000) begin
         failures++; $display("FAIL add_5_3 Y=%h flags=%b required 00000008/00000", Y, {carry, overflow, zero, lt, ltu});
      end
      @(negedge clk);
   endtask

   task automatic test_carry_ripple;
      int n;
      drive(32'hFFFFFFFF, 32'd1, 1'b0);
      wait_out(n);
      checks++;
      if (out_valid !== 1'b1 || Y !== 32'h0 || {carry, overflow, zero, lt, ltu} !== 5'b10100) begin
         failures++; $display("FAIL carry_ripple v=%b Y=%h flags=%b required 1/00000000/10100", out_valid, Y, {carry, overflow, zero, lt, ltu});
      end
      @(negedge clk);
   endtask

   task automatic test_overflow;
      int n;
      logic [31:0] e1, e2;
`ifdef SUMA_RESTA_SAT_EN
      e1 = 32'h7FFFFFFF; e2 = 32'h80000000;
`else
      e1 = 32'h80000000; e2 = 32'h7FFFFFFF;
`endif
      drive(32'h7FFFFFFF, 32'd1, 1'b0);
      wait_out(n);
      checks++;
      if (out_valid !== 1'b1 || Y !== e1 || {carry, overflow, zero, lt, ltu} !== 5'b01000) begin
         failures++; $display("FAIL ovf_add v=%b Y=%h flags=%b required 1/%h/01000", out_valid, Y, {carry, overflow, zero, lt, ltu}, e1);
      end
      @(negedge clk);
      drive(32'h80000000, 32'd1, 1'b1);
      wait_out(n);
      checks++;
      if (out_valid !== 1'b1 || Y !== e2 || {carry, overflow, zero, lt, ltu} !== 5'b11010) begin
         failures++; $display("FAIL ovf_sub v=%b Y=%h flags=%b required 1/%h/11010", out_valid, Y, {carry, overflow, zero, lt, ltu}, e2);
      end
      @(negedge clk);
   endtask

   task automatic test_sub;
      int n;
      drive(32'hFFFFFC18, 32'd1000, 1'b1);
      wait_out(n);
      checks++;
      if (out_valid !== 1'b1 || Y !== 32'hFFFFF830 || {carry, overflow, zero, lt, ltu} !== 5'b10010) begin
         failures++; $display("FAIL sub_neg v=%b Y=%h flags=%b required 1/fffff830/10010", out_valid, Y, {carry, overflow, zero, lt, ltu});
      end
      @(negedge clk);
      drive(32'd3, 32'd5, 1'b1);
      wait_out(n);
      checks++;
      if (out_valid !== 1'b1 || Y !== 32'hFFFFFFFE || {carry, overflow, zero, lt, ltu} !== 5'b00011) begin
         failures++; $display("FAIL sub_borrow v=%b Y=%h flags=%b required 1/fffffffe/00011", out_valid, Y, {carry, overflow, zero, lt, ltu});
      end
      @(negedge clk);
      drive(32'd7, 32'd7, 1'b1);
      wait_out(n);
      checks++;
      if (out_valid !== 1'b1 || Y !== 32'h0 || {carry, overflow, zero, lt, ltu} !== 5'b10100) begin
         failures++; $display("FAIL sub_equal v=%b Y=%h flags=%b required 1/00000000/10100", out_valid, Y, {carry, overflow, zero, lt, ltu});
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] va [4];
      logic [31:0] vb [4];
      logic        vr [4];
      logic [31:0] ye [4];
      va[0] = 32'd1;     vb[0] = 32'd2;    vr[0] = 1'b0; ye[0] = 32'd3;
      va[1] = 32'd10;    vb[1] = 32'd3;    vr[1] = 1'b1; ye[1] = 32'd7;
      va[2] = 32'h100;   vb[2] = 32'hFF;   vr[2] = 1'b0; ye[2] = 32'h1FF;
      va[3] = 32'hFFFF;  vb[3] = 32'd1;    vr[3] = 1'b0; ye[3] = 32'h10000;
      for (int i = 0; i < 4; i++) begin
         a = va[i]; b = vb[i]; resta = vr[i]; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || Y !== ye[0]) begin
            failures++; $display("FAIL stall_hold cyc=%0d v=%b in_ready=%b Y=%h required 1/0/%h", j, out_valid, in_ready, Y, ye[0]);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || Y !== ye[i]) begin
            failures++; $display("FAIL b2b_order idx=%0d v=%b Y=%h required 1/%h", i, out_valid, Y, ye[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_no_dup out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset_flight;
      int seen = 0;
      a = 32'h11; b = 32'h22; resta = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 32'h33; b = 32'h44;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || Y !== 32'h0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL flight_reset v=%b Y=%h in_ready=%b required 0/00000000/1", out_valid, Y, in_ready);
      end
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++; $display("FAIL flight_discard emitted=%0d required 0", seen);
      end
   endtask

   task automatic test_random;
      logic [36:0] q [$];
      logic [36:0] exp_v;
      logic        pend = 1'b0;
      int          sent = 0;
      int          got  = 0;
      int          cyc  = 0;
      int          sa, sb;
      longint      s;
      logic        r, ec, eo;
      logic [31:0] ey;
      while (got < 40 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!pend) begin
            in_valid = 1'b0;
            if (sent < 40 && $urandom_range(3) != 0) begin
               sa = int'($urandom_range(2000)) - 1000;
               sb = int'($urandom_range(2000)) - 1000;
               r  = 1'($urandom_range(1));
               a = sa; b = sb; resta = r; in_valid = 1'b1; pend = 1'b1;
            end
         end
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (in_valid && in_ready) begin
            s  = resta ? longint'(sa) - longint'(sb) : longint'(sa) + longint'(sb);
            ey = s[31:0];
            eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            ec = resta ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF);
            q.push_back({ey, ec, eo, ey == 32'h0, resta && (sa < sb), resta && (a < b)});
            pend = 1'b0;
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rand_extra Y=%h emitted with no beat outstanding", Y);
            end else begin
               exp_v = q.pop_front();
               if ({Y, carry, overflow, zero, lt, ltu} !== exp_v) begin
                  failures++; $display("FAIL rand_beat idx=%0d got=%h/%b required %h/%b", got, Y, {carry, overflow, zero, lt, ltu}, exp_v[36:5], exp_v[4:0]);
               end
            end
            got++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got !== 40) begin
         failures++; $display("FAIL rand_timeout results=%0d required 40", got);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_add_basic;
      test_carry_ripple;
      test_overflow;
      test_sub;
      test_back_to_back;
      test_reset_flight;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
